// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: grants one requester,
// runs one fixed-latency access and returns a registered response.
module dmem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int MEM_LAT = 2,
  parameter int RR      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_resp_valid,
  output logic          p0_resp_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_resp_valid,
  output logic          p1_resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state  | meaning
  // IDLE   | arbitrate, accept one request
  // ISSUE  | mem_en pulse, load latency counter
  // WAIT   | count down, capture load data at zero
  // RESP   | one-cycle response to the granted port
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          last_port;
  logic          lat_port;
  logic [3:0]    cnt;
  logic          pick1;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // last_port resets to 1 so that port 0 wins the first tie
  assign pick1 = (p0_valid && p1_valid) ? ((RR != 0) && !last_port) : p1_valid;

  assign p0_ready  = rst && (state == IDLE) && p0_valid && !pick1;
  assign p1_ready  = rst && (state == IDLE) && p1_valid && pick1;
  assign accept    = p0_ready || p1_ready;
  assign sel_we    = pick1 ? p1_we    : p0_we;
  assign sel_addr  = pick1 ? p1_addr  : p0_addr;
  assign sel_wdata = pick1 ? p1_wdata : p0_wdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_port     <= 1'b1;
      lat_port      <= 1'b0;
      cnt           <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      resp_rdata    <= '0;
      p0_resp_valid <= 1'b0;
      p0_resp_err   <= 1'b0;
      p1_resp_valid <= 1'b0;
      p1_resp_err   <= 1'b0;
    end else begin
      mem_en        <= 1'b0;
      p0_resp_valid <= 1'b0;
      p0_resp_err   <= 1'b0;
      p1_resp_valid <= 1'b0;
      p1_resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_port <= pick1;
            lat_port  <= pick1;
            if (sel_addr[2:0] != 3'd0) begin
              // misaligned: answer with an error, memory untouched
              p0_resp_valid <= !pick1;
              p0_resp_err   <= !pick1;
              p1_resp_valid <= pick1;
              p1_resp_err   <= pick1;
              state         <= RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= 4'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!mem_we) resp_rdata <= mem_rdata;
            p0_resp_valid <= !lat_port;
            p1_resp_valid <= lat_port;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance fully checked,
// plus a fixed-priority instance checked for its grant behaviour.
module tb_dmem_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam logic [63:0] JUNK = 64'hBADC_0FFE_E0DD_F00D;

  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } req_t;
  typedef struct { int cyc; logic we; logic [63:0] addr; logic [63:0] wdata; } iss_t;
  typedef struct { int cyc; logic port; logic err; logic [63:0] rd; } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_valid = 1'b0, p0_we = 1'b0, p1_valid = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
  logic [DW-1:0] resp_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = JUNK;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  logic          f_p0_ready, f_p1_ready, f_p0_rv, f_p1_rv, f_p0_err, f_p1_err;
  logic          f_mem_en, f_mem_we, f_busy;
  logic [DW-1:0] f_rdata, f_mem_wdata;
  logic [AW-1:0] f_mem_addr;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .RR(1)) u_dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_err(p0_resp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_err(p1_resp_err),
    .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(f_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_resp_valid(f_p0_rv), .p0_resp_err(f_p0_err),
    .p1_valid(p1_valid), .p1_ready(f_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_resp_valid(f_p1_rv), .p1_resp_err(f_p1_err),
    .resp_rdata(f_rdata), .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .busy(f_busy));

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  req_t  pend0[$], pend1[$];
  iss_t  iss_q[$];
  resp_t resp_q[$];
  int    grants[$];
  int    next_idle = 0;
  logic  tb_last = 1'b1;
  logic [63:0] tb_rd = '0;
  logic  acc0 = 1'b0, acc1 = 1'b0;
  logic  fp_phase = 1'b0;
  int    fp_grants = 0;

  logic        m_idle, m_w, m_e0, m_e1, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [1:0]  m_rv;
  iss_t        m_i;
  resp_t       m_r;
  int          mcnt = 0;
  logic [63:0] maddr = '0;

  function automatic logic [63:0] mem_model(logic [63:0] a);
    return (a == 64'h10) ? 64'hDEAD : (a * 64'd3 + 64'h5A5A);
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_req(int port, logic we, logic [63:0] addr, logic [63:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (port == 0) pend0.push_back(r); else pend1.push_back(r);
  endtask

  task automatic drain(int budget);
    int i = 0;
    while (i < budget && (resp_q.size() != 0 || iss_q.size() != 0 ||
                          pend0.size() != 0 || pend1.size() != 0)) begin
      @(negedge clk); #1;
      i++;
    end
    if (i >= budget) check_eq("drain_timeout", 64'(resp_q.size() + pend0.size() + pend1.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // requester: present the head of each pending queue until it is taken
  initial forever begin
    @(posedge clk); #1;
    if (acc0) begin if (pend0.size() != 0) pend0.delete(0); acc0 = 1'b0; end
    if (acc1) begin if (pend1.size() != 0) pend1.delete(0); acc1 = 1'b0; end
    p0_valid = (pend0.size() != 0);
    if (p0_valid) begin p0_we = pend0[0].we; p0_addr = pend0[0].addr; p0_wdata = pend0[0].wdata; end
    p1_valid = (pend1.size() != 0);
    if (p1_valid) begin p1_we = pend1[0].we; p1_addr = pend1[0].addr; p1_wdata = pend1[0].wdata; end
  end

  // memory: data is valid only in the cycle LAT after mem_en
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mcnt = 0; mem_rdata = JUNK;
    end else begin
      if (mcnt != 0) begin
        mcnt--;
        mem_rdata = (mcnt == 0) ? mem_model(maddr) : JUNK;
      end else mem_rdata = JUNK;
      if (mem_en) begin mcnt = LAT; maddr = mem_addr; end
    end
  end

  // grant model and scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_idle = (cyc >= next_idle);
      if (p0_valid || p1_valid) begin
        m_w  = (p0_valid && p1_valid) ? !tb_last : p1_valid;
        m_e0 = m_idle && p0_valid && !m_w;
        m_e1 = m_idle && p1_valid && m_w;
        check_eq("p0_ready", 64'(p0_ready), 64'(m_e0));
        check_eq("p1_ready", 64'(p1_ready), 64'(m_e1));
        if (p0_ready && p0_valid) grants.push_back(0);
        if (p1_ready && p1_valid) grants.push_back(1);
        if (m_e0 || m_e1) begin
          m_we    = m_w ? p1_we : p0_we;
          m_addr  = m_w ? p1_addr : p0_addr;
          m_wdata = m_w ? p1_wdata : p0_wdata;
          tb_last = m_w;
          if (m_w) acc1 = 1'b1; else acc0 = 1'b1;
          m_r.port = m_w;
          if (m_addr[2:0] != 3'd0) begin
            m_r.cyc = cyc + 1; m_r.err = 1'b1; m_r.rd = tb_rd;
            next_idle = cyc + 2;
          end else begin
            m_i.cyc = cyc + 1; m_i.we = m_we; m_i.addr = m_addr; m_i.wdata = m_wdata;
            iss_q.push_back(m_i);
            if (!m_we) tb_rd = mem_model(m_addr);
            m_r.cyc = cyc + LAT + 2; m_r.err = 1'b0; m_r.rd = tb_rd;
            next_idle = cyc + LAT + 3;
          end
          resp_q.push_back(m_r);
        end
      end
      check_eq("busy", 64'(busy), 64'(!m_idle));

      if (mem_en) begin
        if (iss_q.size() == 0) check_eq("mem_en_unexpected", 64'(mem_en), 64'd0);
        else begin
          m_i = iss_q.pop_front();
          check_eq("mem_en_cycle", 64'(cyc), 64'(m_i.cyc));
          check_eq("mem_we", 64'(mem_we), 64'(m_i.we));
          check_eq("mem_addr", mem_addr, m_i.addr);
          if (m_i.we) check_eq("mem_wdata", mem_wdata, m_i.wdata);
        end
      end else if (iss_q.size() != 0 && cyc > iss_q[0].cyc) begin
        check_eq("mem_en_missing", 64'(mem_en), 64'd1);
        void'(iss_q.pop_front());
      end

      m_rv = {p1_resp_valid, p0_resp_valid};
      if (m_rv != 2'b00) begin
        if (resp_q.size() == 0) check_eq("resp_unexpected", 64'(m_rv), 64'd0);
        else begin
          m_r = resp_q.pop_front();
          check_eq("resp_port", 64'(m_rv), m_r.port ? 64'd2 : 64'd1);
          check_eq("resp_cycle", 64'(cyc), 64'(m_r.cyc));
          check_eq("resp_err", 64'(m_r.port ? p1_resp_err : p0_resp_err), 64'(m_r.err));
          check_eq("resp_rdata", resp_rdata, m_r.rd);
        end
      end else if (resp_q.size() != 0 && cyc > resp_q[0].cyc) begin
        check_eq("resp_missing", 64'(m_rv), m_r.port ? 64'd2 : 64'd1);
        void'(resp_q.pop_front());
      end

      if (fp_phase && (f_p0_ready || f_p1_ready)) begin
        check_eq("fp_p1_ready", 64'(f_p1_ready), 64'd0);
        fp_grants++;
      end
    end
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_en", 64'(mem_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_resp_rdata", resp_rdata, 64'd0);
    p0_valid = 1'b1;
    #1;
    check_eq("rst_p0_ready", 64'(p0_ready), 64'd0);
    p0_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;

    push_req(0, 1'b0, 64'h10, 64'h0);
    drain(100);
    push_req(1, 1'b1, 64'h28, 64'h1234);
    drain(100);
    push_req(0, 1'b0, 64'h13, 64'h0);
    drain(100);

    grants.delete();
    fp_phase = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_req(0, 1'b0, 64'h100 + 64'(k * 8), 64'h0);
      push_req(1, 1'b1, 64'h200 + 64'(k * 8), 64'hA000 + 64'(k));
    end
    drain(300);
    fp_phase = 1'b0;
    check_eq("rr_grant_count", 64'(grants.size()), 64'd8);
    for (int k = 0; k < grants.size(); k++)
      check_eq("rr_grant_order", 64'(grants[k]), (k % 2 == 0) ? 64'd1 : 64'd0);
    check_eq("fp_p0_grants", 64'(fp_grants >= 3), 64'd1);

    grants.delete();
    push_req(0, 1'b0, 64'h40, 64'h0);
    i = 0;
    while (grants.size() == 0 && i < 50) begin @(negedge clk); #1; i++; end
    check_eq("abort_grant_seen", 64'(grants.size() != 0), 64'd1);
    @(posedge clk);
    @(posedge clk); #3;
    push_req(0, 1'b0, 64'h48, 64'h0);
    push_req(1, 1'b0, 64'h50, 64'h0);
    rst = 1'b0;
    #1;
    iss_q.delete(); resp_q.delete();
    next_idle = 0; tb_last = 1'b1; tb_rd = '0;
    check_eq("abort_mem_en", 64'(mem_en), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
    check_eq("abort_mem_addr", mem_addr, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    grants.delete();
    rst = 1'b1;
    drain(200);
    check_eq("rst_first_tie", (grants.size() != 0) ? 64'(grants[0]) : 64'd9, 64'd0);
    check_eq("final_resp_q", 64'(resp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
